ram_cmd_master: RTL and testbench
=================================

# ram_cmd_master

Command initiator for the single-port RAM slave's 10-bit frame protocol. Accepts one read or write request at a time on a valid/ready port and serialises it into opcode-tagged frames on `din`/`rx_valid`. For reads, it waits for the RAM's `tx_valid`/`dout` reply and returns the data, or an error on timeout. It sits between the host-side controller and the RAM, replacing hand-driven frame stimulus.

## Interface
- `ADDR_SIZE`, default 8: width of address and data fields. The frame is `ADDR_SIZE+2` bits wide.
- `TIMEOUT`, default 16: maximum number of cycles spent waiting for `tx_valid` after a read command frame.

- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  a request is presented.
- `req_ready`  out  1  the block accepts a request this cycle.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_SIZE  target address.
- `req_wdata`  in  ADDR_SIZE  write data; ignored for reads.
- `rsp_valid`  out  1  single-cycle response pulse.
- `rsp_rdata`  out  ADDR_SIZE  read data; 0 for writes and errors.
- `rsp_err`  out  1  read timed out; qualified by `rsp_valid`.
- `din`  out  ADDR_SIZE+2  frame to the RAM: opcode in bits [ADDR_SIZE+1:ADDR_SIZE], payload below.
- `rx_valid`  out  1  frame qualifier to the RAM.
- `dout`  in  ADDR_SIZE  RAM read data.
- `tx_valid`  in  1  RAM read data valid.

## Operation
- Opcodes:
  - 00 = write address.
  - 01 = write data.
  - 10 = read address.
  - 11 = read command; payload is 0.
- Idle frame is all-zero `din` with `rx_valid`=0.
  - The RAM acts on opcode 11 regardless of `rx_valid`, so `din` must never hold opcode 11 except during the RCMD cycle.
- All outputs are registered.
- Reset value of every output is 0: `req_ready`, `rsp_valid`, `rsp_rdata`, `rsp_err`, `din`, `rx_valid`.
  - `req_ready` rises in the first cycle after `rst` deasserts.
- Handshake: a request is accepted when `req_valid`&&`req_ready`. `req_*` fields are captured at that edge.
- Only one request is outstanding at a time. There is no response backpressure.
- FSM states: IDLE, WADDR, WDATA, RADDR, RCMD, RWAIT, RESP.
  - IDLE: `req_ready`=1. On accept, go to WADDR if `req_write`, otherwise RADDR.
  - WADDR: drive {00,addr} with `rx_valid`=1, then go to WDATA.
  - WDATA: drive {01,wdata} with `rx_valid`=1, then go to RESP.
  - RADDR: drive {10,addr} with `rx_valid`=1, then go to RCMD.
  - RCMD: drive {11,0} with `rx_valid`=1, then go to RWAIT.
  - RWAIT: idle frame. Increment the timeout counter each cycle.
    - `tx_valid`=1 → capture `dout`, go to RESP.
    - Counter reaches `TIMEOUT` → go to RESP with error.
  - RESP: `rsp_valid`=1 for one cycle, `req_ready`=0, idle frame. Then go to IDLE.
- Timeout counter:
  - Width $clog2(TIMEOUT+1).
  - Cleared on entry to RWAIT.
  - A `tx_valid` arriving in the same cycle the counter hits `TIMEOUT` wins: good data, `rsp_err`=0.
- `tx_valid` outside RWAIT is ignored.
- Reset mid-operation drops the in-flight request: no response, FSM to IDLE, outputs to 0.

## Timing
- The accept edge is at the end of cycle 0. The first frame appears in cycle 1.
- Write, no cache hit:
  - Frames in cycles 1–2.
  - `rsp_valid` in cycle 3.
  - Next accept possible in cycle 4.
- Read, no cache hit:
  - Frames in cycles 1–2.
  - Nominal RAM `tx_valid` in cycle 3.
  - `rsp_valid` with data in cycle 4.
  - Next accept possible in cycle 5.
- Timeout read:
  - `rsp_valid` with `rsp_err`=1 in cycle 3+TIMEOUT.

## Configuration
- `RAM_MASTER_ADDR_CACHE_EN` defined:
  - Keep `last_waddr`/`last_raddr` registers, each with a valid bit. Valid bits are cleared by `rst`.
  - Each register is updated when its address frame is issued.
  - A write whose address matches a valid `last_waddr` skips WADDR and goes straight to WDATA: `rsp_valid` in cycle 2.
  - A read whose address matches a valid `last_raddr` skips RADDR: `rsp_valid` in cycle 3.
- Undefined: no cache registers. Every request sends its address frame.

## Test plan
- Write 0xA5 to 0x3C → cycle 1 `din`=0x03C, cycle 2 `din`=0x1A5 (`rx_valid`=1 both); cycle 3 `rsp_valid`=1, `rsp_err`=0, `rsp_rdata`=0.
- Read 0x3C after that write, RAM model attached → cycle 1 `din`=0x23C, cycle 2 `din`=0x300; cycle 4 `rsp_valid`=1, `rsp_rdata`=0xA5.
- Read with `tx_valid` held 0, TIMEOUT=16 → `rsp_valid`=1, `rsp_err`=1, `rsp_rdata`=0 in cycle 19; `din` never holds opcode 11 after cycle 2.
- Assert `rst` in the RCMD cycle of a read → next cycle all outputs 0, no `rsp_valid`; a following write completes normally.
- Back-to-back writes to 0x10 with `req_valid` held high → second accept in cycle 4. With cache: second write's data frame appears in the cycle right after its accept, with no 0x010 frame. Without cache: the 0x010 address frame is re-sent.
- Spurious `tx_valid` pulse in IDLE, then a normal read of 0x00 → the pulse is ignored; a single `rsp_valid` carries the true RAM value.

Source files
------------

// File: rtl/ram_cmd_master.sv
// ram_cmd_master: serialises one read/write request into 10-bit
// opcode frames for the single-port RAM slave and returns read data.
// Ports: clk, rst (sync, active-high); req_valid/req_ready/req_write/
// req_addr/req_wdata request side; rsp_valid/rsp_rdata/rsp_err
// response side; din/rx_valid frames out; dout/tx_valid RAM reply.
// Optional address cache: define RAM_MASTER_ADDR_CACHE_EN.
module ram_cmd_master #(
  parameter int ADDR_SIZE = 8,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [ADDR_SIZE-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [ADDR_SIZE-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic [ADDR_SIZE+1:0] din,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] dout,
  input  logic                 tx_valid
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WADDR = 3'd1;
  localparam logic [2:0] S_WDATA = 3'd2;
  localparam logic [2:0] S_RADDR = 3'd3;
  localparam logic [2:0] S_RCMD  = 3'd4;
  localparam logic [2:0] S_RWAIT = 3'd5;
  localparam logic [2:0] S_RESP  = 3'd6;

  logic [2:0]           state;
  logic [2:0]           nxt;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [ADDR_SIZE-1:0] wdata_q;
  logic [ADDR_SIZE-1:0] addr_src;
  logic [ADDR_SIZE-1:0] wdata_src;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_inc;
  logic                 accept;
  logic                 timeout;
  logic                 w_hit;
  logic                 r_hit;
  logic [ADDR_SIZE+1:0] din_n;
  logic                 rx_n;

  assign accept  = (state == S_IDLE) && req_valid && req_ready;
  assign cnt_inc = cnt + CW'(1);
  assign timeout = (cnt_inc == TO_MAX);

  // Frames leaving IDLE are built from the request itself, since
  // the capture registers load on that same edge.
  assign addr_src  = accept ? req_addr  : addr_q;
  assign wdata_src = accept ? req_wdata : wdata_q;

`ifdef RAM_MASTER_ADDR_CACHE_EN
  logic [ADDR_SIZE-1:0] last_waddr;
  logic [ADDR_SIZE-1:0] last_raddr;
  logic                 waddr_ok;
  logic                 raddr_ok;

  assign w_hit = waddr_ok && (last_waddr == req_addr);
  assign r_hit = raddr_ok && (last_raddr == req_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_waddr <= '0;
      last_raddr <= '0;
      waddr_ok   <= 1'b0;
      raddr_ok   <= 1'b0;
    end else if (accept) begin
      if (nxt == S_WADDR) begin
        last_waddr <= req_addr;
        waddr_ok   <= 1'b1;
      end
      if (nxt == S_RADDR) begin
        last_raddr <= req_addr;
        raddr_ok   <= 1'b1;
      end
    end
  end
`else
  assign w_hit = 1'b0;
  assign r_hit = 1'b0;
`endif

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (req_write) nxt = w_hit ? S_WDATA : S_WADDR;
          else           nxt = r_hit ? S_RCMD  : S_RADDR;
        end
      end
      S_WADDR: nxt = S_WDATA;
      S_WDATA: nxt = S_RESP;
      S_RADDR: nxt = S_RCMD;
      S_RCMD:  nxt = S_RWAIT;
      S_RWAIT: begin
        if (tx_valid || timeout) nxt = S_RESP;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so the frame for a
  // state is on din during the cycle the FSM sits in it.
  always_comb begin
    din_n = '0;
    rx_n  = 1'b0;
    case (nxt)
      S_WADDR: begin
        din_n = {2'b00, addr_src};
        rx_n  = 1'b1;
      end
      S_WDATA: begin
        din_n = {2'b01, wdata_src};
        rx_n  = 1'b1;
      end
      S_RADDR: begin
        din_n = {2'b10, addr_src};
        rx_n  = 1'b1;
      end
      S_RCMD: begin
        din_n = {2'b11, {ADDR_SIZE{1'b0}}};
        rx_n  = 1'b1;
      end
      default: begin
        din_n = '0;
        rx_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt       <= '0;
      din       <= '0;
      rx_valid  <= 1'b0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      // Held at zero outside RWAIT, so it is clear on entry.
      if (state == S_RWAIT) cnt <= cnt_inc;
      else                  cnt <= '0;
      din       <= din_n;
      rx_valid  <= rx_n;
      req_ready <= (nxt == S_IDLE);
      rsp_valid <= (nxt == S_RESP);
      // tx_valid on the timeout cycle wins over the error.
      rsp_err   <= (state == S_RWAIT) && !tx_valid && timeout;
      rsp_rdata <= ((state == S_RWAIT) && tx_valid) ? dout : '0;
    end
  end

endmodule

// File: tb/tb_ram_cmd_master.sv
// tb_ram_cmd_master: directed bench for ram_cmd_master with a small
// behavioural RAM slave attached to the frame port.
module tb_ram_cmd_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] dout;
  logic       tx_valid;

  logic       ram_en;
  logic       ram_tx;
  logic [7:0] ram_dout;
  logic       spur;
  logic [7:0] spur_data;
  logic [7:0] m_waddr;
  logic [7:0] m_raddr;
  logic [7:0] mem [256];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign tx_valid = ram_tx | spur;
  assign dout     = spur ? spur_data : ram_dout;

  ram_cmd_master #(.ADDR_SIZE(8), .TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .din       (din),
    .rx_valid  (rx_valid),
    .dout      (dout),
    .tx_valid  (tx_valid)
  );

  // RAM slave: acts on opcode 11 regardless of rx_valid.
  always @(posedge clk) begin
    if (din[9:8] == 2'b11) begin
      ram_tx   <= ram_en;
      ram_dout <= mem[m_raddr];
    end else begin
      ram_tx <= 1'b0;
    end
    if (rx_valid) begin
      case (din[9:8])
        2'b00:   m_waddr <= din[7:0];
        2'b01:   mem[m_waddr] <= din[7:0];
        2'b10:   m_raddr <= din[7:0];
        default: ;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic w, input logic [7:0] a,
                     input logic [7:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rspv"},  32'(rsp_valid), 32'd0);
    chk({tag, "_rdata"}, 32'(rsp_rdata), 32'd0);
    chk({tag, "_err"},   32'(rsp_err),   32'd0);
    chk({tag, "_din"},   32'(din),       32'd0);
    chk({tag, "_rxv"},   32'(rx_valid),  32'd0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    ram_en = 1'b1;
    ram_tx = 1'b0;
    ram_dout = '0;
    spur = 1'b0;
    spur_data = '0;
    m_waddr = '0;
    m_raddr = '0;
    tick();
    tick();
    all_zero("reset");
    rst = 1'b0;
    tick();
    chk("rdy_after_rst", 32'(req_ready), 32'd1);

    // Write 0xA5 to 0x3C
    req(1'b1, 8'h3C, 8'hA5);
    tick();
    req_valid = 1'b0;
    chk("w_c1_din", 32'(din), 32'h03C);
    chk("w_c1_rxv", 32'(rx_valid), 32'd1);
    chk("w_c1_rdy", 32'(req_ready), 32'd0);
    tick();
    chk("w_c2_din", 32'(din), 32'h1A5);
    chk("w_c2_rxv", 32'(rx_valid), 32'd1);
    tick();
    chk("w_c3_rspv", 32'(rsp_valid), 32'd1);
    chk("w_c3_err", 32'(rsp_err), 32'd0);
    chk("w_c3_rdata", 32'(rsp_rdata), 32'd0);
    chk("w_c3_din", 32'(din), 32'd0);
    chk("w_c3_rxv", 32'(rx_valid), 32'd0);
    tick();
    chk("w_c4_rspv", 32'(rsp_valid), 32'd0);
    chk("w_c4_rdy", 32'(req_ready), 32'd1);

    // Read 0x3C back
    req(1'b0, 8'h3C, 8'h00);
    tick();
    req_valid = 1'b0;
    chk("r_c1_din", 32'(din), 32'h23C);
    chk("r_c1_rxv", 32'(rx_valid), 32'd1);
    tick();
    chk("r_c2_din", 32'(din), 32'h300);
    chk("r_c2_rxv", 32'(rx_valid), 32'd1);
    tick();
    chk("r_c3_din", 32'(din), 32'd0);
    chk("r_c3_rxv", 32'(rx_valid), 32'd0);
    chk("r_c3_rspv", 32'(rsp_valid), 32'd0);
    tick();
    chk("r_c4_rspv", 32'(rsp_valid), 32'd1);
    chk("r_c4_rdata", 32'(rsp_rdata), 32'hA5);
    chk("r_c4_err", 32'(rsp_err), 32'd0);
    tick();
    chk("r_c5_rdy", 32'(req_ready), 32'd1);
    chk("r_c5_rspv", 32'(rsp_valid), 32'd0);

    // Timeout read, RAM silent
    ram_en = 1'b0;
    req(1'b0, 8'h55, 8'h00);
    tick();
    req_valid = 1'b0;
    chk("to_c1_din", 32'(din), 32'h255);
    tick();
    chk("to_c2_din", 32'(din), 32'h300);
    for (int c = 3; c <= 18; c++) begin
      tick();
      chk("to_wait_rspv", 32'(rsp_valid), 32'd0);
      chk("to_wait_op11", 32'(din[9:8] == 2'b11), 32'd0);
    end
    tick();
    chk("to_c19_rspv", 32'(rsp_valid), 32'd1);
    chk("to_c19_err", 32'(rsp_err), 32'd1);
    chk("to_c19_rdata", 32'(rsp_rdata), 32'd0);
    chk("to_c19_op", 32'(din), 32'd0);
    tick();
    chk("to_c20_rdy", 32'(req_ready), 32'd1);

    // tx_valid on the very cycle the timeout would fire
    req(1'b0, 8'h66, 8'h00);
    tick();
    req_valid = 1'b0;
    tick();
    for (int c = 3; c <= 18; c++) tick();
    spur = 1'b1;
    spur_data = 8'h9E;
    tick();
    spur = 1'b0;
    chk("tb_c19_rspv", 32'(rsp_valid), 32'd1);
    chk("tb_c19_err", 32'(rsp_err), 32'd0);
    chk("tb_c19_rdata", 32'(rsp_rdata), 32'h9E);
    tick();
    ram_en = 1'b1;
    chk("tb_c20_rdy", 32'(req_ready), 32'd1);

    // Reset during the RCMD cycle of a read
    req(1'b0, 8'h77, 8'h00);
    tick();
    req_valid = 1'b0;
    chk("rr_c1_din", 32'(din), 32'h277);
    tick();
    chk("rr_c2_din", 32'(din), 32'h300);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    all_zero("rr_c3");
    tick();
    chk("rr_c4_rspv", 32'(rsp_valid), 32'd0);
    chk("rr_c4_rdy", 32'(req_ready), 32'd1);
    req(1'b1, 8'h20, 8'h5B);
    tick();
    req_valid = 1'b0;
    chk("rw_c1_din", 32'(din), 32'h020);
    tick();
    chk("rw_c2_din", 32'(din), 32'h15B);
    tick();
    chk("rw_c3_rspv", 32'(rsp_valid), 32'd1);
    chk("rw_c3_err", 32'(rsp_err), 32'd0);
    tick();
    chk("rw_c4_rdy", 32'(req_ready), 32'd1);

    // Back-to-back writes to 0x10, req_valid held high
    req(1'b1, 8'h10, 8'h01);
    tick();
    req_wdata = 8'h02;
    chk("bb_c1_din", 32'(din), 32'h010);
    tick();
    chk("bb_c2_din", 32'(din), 32'h101);
    tick();
    chk("bb_c3_rspv", 32'(rsp_valid), 32'd1);
    chk("bb_c3_rdy", 32'(req_ready), 32'd0);
    tick();
    chk("bb_c4_rdy", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
`ifdef RAM_MASTER_ADDR_CACHE_EN
    chk("bb_c5_din", 32'(din), 32'h102);
    tick();
    chk("bb_c6_rspv", 32'(rsp_valid), 32'd1);
    tick();
`else
    chk("bb_c5_din", 32'(din), 32'h010);
    tick();
    chk("bb_c6_din", 32'(din), 32'h102);
    tick();
    chk("bb_c7_rspv", 32'(rsp_valid), 32'd1);
    tick();
`endif
    chk("bb_end_rdy", 32'(req_ready), 32'd1);

    // Load 0xC3 at 0x00, spurious tx_valid in IDLE, then read
    req(1'b1, 8'h00, 8'hC3);
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    chk("sp_w_rspv", 32'(rsp_valid), 32'd1);
    tick();
    spur = 1'b1;
    spur_data = 8'hEE;
    tick();
    spur = 1'b0;
    chk("sp_idle_rspv", 32'(rsp_valid), 32'd0);
    chk("sp_idle_rdy", 32'(req_ready), 32'd1);
    req(1'b0, 8'h00, 8'h00);
    tick();
    req_valid = 1'b0;
    chk("sp_c1_din", 32'(din), 32'h200);
    tick();
    chk("sp_c2_din", 32'(din), 32'h300);
    tick();
    chk("sp_c3_rspv", 32'(rsp_valid), 32'd0);
    tick();
    chk("sp_c4_rspv", 32'(rsp_valid), 32'd1);
    chk("sp_c4_rdata", 32'(rsp_rdata), 32'hC3);
    chk("sp_c4_err", 32'(rsp_err), 32'd0);
    tick();
    chk("sp_c5_rspv", 32'(rsp_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
